fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter BITS, default 12, meaning the width of one FIFO word.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the completed-pair counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit, the system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-006 SHALL have port fifo_ready, input, 1 bit; high means the upstream FIFO holds at least one word.
REQ-007 SHALL have port fifo_data, input, BITS bits; FIFO read data, valid one cycle after fifo_read.
REQ-008 SHALL have port fifo_overflow, input, 1 bit, the upstream overflow status.
REQ-009 SHALL have port fifo_read, output, 1 bit, a one-cycle read strobe to the FIFO.
REQ-010 SHALL have port out_data, output, 2*BITS bits, a packed pair {second word, first word}.
REQ-011 SHALL have port out_valid, output, 1 bit; high means out_data holds a complete pair.
REQ-012 SHALL have port out_ready, input, 1 bit; the downstream accepts when out_valid and out_ready are both high.
REQ-013 SHALL have port pair_cnt, output, CNT_W bits, counting accepted pairs.
REQ-014 SHALL have port ovf_sticky, output, 1 bit, set and held once fifo_overflow has been seen.

Function
REQ-015 SHALL implement FSM states IDLE, RD_LO, CAP_LO, WAIT_HI, RD_HI, CAP_HI and OUT.
REQ-016 SHALL make these transitions:
- IDLE -> RD_LO when fifo_ready=1.
- RD_LO -> CAP_LO unconditionally.
- CAP_LO -> RD_HI when fifo_ready=1; otherwise CAP_LO -> WAIT_HI.
- WAIT_HI -> RD_HI when fifo_ready=1.
- RD_HI -> CAP_HI unconditionally.
- CAP_HI -> OUT unconditionally.
- OUT -> IDLE when out_ready=1.
REQ-017 SHALL assert fifo_read only in RD_LO and RD_HI, each for exactly one cycle.
REQ-018 SHALL never assert fifo_read while fifo_ready=0 is sampled in the preceding decision state.
REQ-019 SHALL capture fifo_data into the low half in CAP_LO and into the high half in CAP_HI.
REQ-020 SHALL have a latency of 6 cycles from fifo_ready rising in IDLE, with data continuously available, to out_valid=1.
REQ-021 SHALL hold out_valid=1 and out_data stable in OUT until the handshake completes.
REQ-022 SHALL hold out_data unchanged outside OUT after a pair is taken, and SHALL never glitch it.
REQ-023 SHALL increment pair_cnt on each OUT handshake and wrap modulo 2^CNT_W.
REQ-024 SHALL set ovf_sticky in the cycle after fifo_overflow=1 and clear it only on reset.
REQ-025 SHALL let the FSM wait indefinitely in WAIT_HI or OUT with no timeout.

Reset
REQ-026 SHALL drive the following on rst=1 at a clock edge: state=IDLE, fifo_read=0, out_valid=0, out_data=0, pair_cnt=0 and ovf_sticky=0.
REQ-027 SHALL discard any half-captured pair when reset is asserted mid-operation; no partial pair is emitted after reset.

Configuration
REQ-028 SHALL, when PACKER_PARITY_EN is defined, add output out_parity (1 bit) equal to the even parity of out_data, registered alongside out_data, with reset value 0.
REQ-029 SHALL, when PACKER_PARITY_EN is undefined, have no out_parity port and no parity logic; all other behaviour is identical.

Structure
REQ-030 SHALL take the FSM state typedef (3-bit encoding) and the default BITS/CNT_W constants from shared package fifo_pkg.
REQ-031 SHALL, under PACKER_PARITY_EN, compute parity in one sub-module, word_parity, parameterised by width; no other sub-modules are used.

Verification
REQ-032 SHALL verify a basic pair: FIFO model with words 0x001, 0x002 and out_ready=1 -> fifo_read pulses twice, out_data=0x002001, out_valid for 1 cycle, pair_cnt=1.
REQ-033 SHALL verify backpressure: out_ready=0 for 10 cycles during OUT -> out_valid stays 1, out_data stays 0x004003 and no further fifo_read; release -> pair_cnt increments once.
REQ-034 SHALL verify an empty gap: one word 0x0e0 present, the second arriving 5 cycles later -> FSM sits in WAIT_HI with fifo_read=0, then out_data=0x0050e0.
REQ-035 SHALL verify a mid-pair reset: rst=1 in CAP_LO -> no out_valid, all outputs 0, and the next pair starts clean from IDLE.
REQ-036 SHALL verify counter wrap and the sticky flag: 256 pairs with CNT_W=8 -> pair_cnt returns to 0; a 1-cycle pulse on fifo_overflow -> ovf_sticky=1 until reset.
REQ-037 SHALL verify parity under PACKER_PARITY_EN: out_data=0x000003 -> out_parity=0, and 0x000001 -> out_parity=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: FSM state encoding and
// default widths for the FIFO word and the completed-pair counter.
package fifo_pkg;

  localparam int DEF_BITS  = 12;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LO   = 3'd1,
    CAP_LO  = 3'd2,
    WAIT_HI = 3'd3,
    RD_HI   = 3'd4,
    CAP_HI  = 3'd5,
    OUT     = 3'd6
  } state_t;

endpackage

// File: rtl/word_parity.sv
// Even-parity generator over a word of configurable width (XOR of all bits).
// Only present in builds with PACKER_PARITY_EN defined.
`ifdef PACKER_PARITY_EN
module word_parity #(
  parameter int W = 24
) (
  input  logic [W-1:0] data,
  output logic         parity
);

  assign parity = ^data;

endmodule
`endif

// File: rtl/fifo_word_packer.sv
// Reads two consecutive words from an upstream FIFO and presents them as one
// packed pair {second, first} with a valid/ready handshake. Counts accepted
// pairs and keeps a sticky copy of the upstream overflow flag.
// Optional feature: define PACKER_PARITY_EN to add out_parity, the even
// parity of out_data, registered together with out_data.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_ready,
  input  logic [BITS-1:0]   fifo_data,
  input  logic              fifo_overflow,
  output logic              fifo_read,
  output logic [2*BITS-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pair_cnt,
`ifdef PACKER_PARITY_EN
  output logic              out_parity,
`endif
  output logic              ovf_sticky
);

  state_t            state;
  logic [BITS-1:0]   lo_word;
  logic [2*BITS-1:0] pair_next;

  // The FIFO returns data one cycle after the strobe, so the capture states
  // sample fifo_data directly; the high word is combined with the stored
  // low word only when the pair is handed to the output register.
  assign pair_next = {fifo_data, lo_word};

`ifdef PACKER_PARITY_EN
  logic pair_par;

  word_parity #(.W(2*BITS)) u_parity (
    .data   (pair_next),
    .parity (pair_par)
  );
`endif

  // Pair sequencer: strobes are issued on entry to the read states so a read
  // only ever follows a cycle in which fifo_ready was sampled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fifo_read <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      lo_word   <= '0;
      pair_cnt  <= '0;
`ifdef PACKER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      fifo_read <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_ready) begin
            state     <= RD_LO;
            fifo_read <= 1'b1;
          end
        end
        RD_LO: state <= CAP_LO;
        CAP_LO: begin
          lo_word <= fifo_data;
          if (fifo_ready) begin
            state     <= RD_HI;
            fifo_read <= 1'b1;
          end else begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (fifo_ready) begin
            state     <= RD_HI;
            fifo_read <= 1'b1;
          end
        end
        RD_HI: state <= CAP_HI;
        CAP_HI: begin
          // out_data is only ever written here, so it holds its last pair
          // through OUT and afterwards until the next pair completes.
          out_data  <= pair_next;
          out_valid <= 1'b1;
`ifdef PACKER_PARITY_EN
          out_parity <= pair_par;
`endif
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pair_cnt  <= pair_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow flag: set the cycle after any overflow pulse, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (fifo_overflow) begin
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: a queue-based upstream FIFO model, a
// reference of which words have been delivered since reset, and one
// per-cycle compare process, plus directed and randomized scenarios.
module tb_fifo_word_packer;

  localparam int BITS  = 12;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_ready = 1'b0;
  logic [BITS-1:0]   fifo_data = '0;
  logic              fifo_overflow = 1'b0;
  logic              fifo_read;
  logic [2*BITS-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  pair_cnt;
  logic              ovf_sticky;
`ifdef PACKER_PARITY_EN
  logic              out_parity;
`endif

  fifo_word_packer #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_ready    (fifo_ready),
    .fifo_data     (fifo_data),
    .fifo_overflow (fifo_overflow),
    .fifo_read     (fifo_read),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pair_cnt      (pair_cnt),
`ifdef PACKER_PARITY_EN
    .out_parity    (out_parity),
`endif
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Upstream FIFO contents, words waiting to be pushed, and words delivered
  // to the DUT since the last reset (the pair under construction).
  logic [BITS-1:0] q[$];
  logic [BITS-1:0] pend[$];
  logic [BITS-1:0] rd_words[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic exp_sticky = 1'b0;
  bit   armed = 1'b0;
  int   total_hs = 0;
  int   rd_pulses = 0;

  bit s_rd = 0, s_rst = 0, s_hs = 0, s_ovf = 0;
  logic [2*BITS-1:0] prev_data = '0;
  bit prev_valid = 0, prev_hs = 0, prev_rst = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [BITS-1:0] w);
    pend.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    bit ok;
    n = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check("out_valid_timeout", 64'(ok), 64'd1);
  endtask

  // FIFO and reference model: applies what was sampled at the last negedge.
  always @(posedge clk) begin
    #1;
    if (s_rd) begin
      if (q.size() != 0) begin
        fifo_data = q.pop_front();
        if (!s_rst) rd_words.push_back(fifo_data);
      end else begin
        fifo_data = 'x;
      end
    end
    if (s_rst) begin
      rd_words.delete();
      exp_cnt    = '0;
      exp_sticky = 1'b0;
      armed      = 1'b1;
    end else begin
      if (s_hs) begin
        exp_cnt = exp_cnt + 1'b1;
        if (rd_words.size() >= 2) begin
          void'(rd_words.pop_front());
          void'(rd_words.pop_front());
        end
      end
      if (s_ovf) exp_sticky = 1'b1;
    end
    while (pend.size() != 0) q.push_back(pend.pop_front());
    fifo_ready = (q.size() != 0);
  end

  // Per-cycle compare against the reference model.
  always @(negedge clk) begin
    if (armed) begin
      if (fifo_read === 1'b1) begin
        rd_pulses++;
        check("read_only_when_ready", 64'(q.size() != 0), 64'd1);
        check("read_single_cycle", 64'(s_rd), 64'd0);
      end
      if (out_valid === 1'b1) begin
        check("valid_has_pair", 64'(rd_words.size()), 64'd2);
        if (out_ready === 1'b1 && rd_words.size() >= 2)
          check("pair_data", 64'(out_data), 64'({rd_words[1], rd_words[0]}));
      end
      check("pair_cnt", 64'(pair_cnt), 64'(exp_cnt));
      check("ovf_sticky", 64'(ovf_sticky), 64'(exp_sticky));
      if (!prev_rst && out_valid !== 1'b1)
        check("out_data_hold_idle", 64'(out_data), 64'(prev_data));
      if (!prev_rst && out_valid === 1'b1 && prev_valid && !prev_hs)
        check("out_data_hold_out", 64'(out_data), 64'(prev_data));
`ifdef PACKER_PARITY_EN
      check("out_parity", 64'(out_parity), 64'(^out_data));
`endif
      if (out_valid === 1'b1 && out_ready === 1'b1 && rst !== 1'b1) total_hs++;
    end
    s_rd  = (fifo_read === 1'b1);
    s_rst = (rst === 1'b1);
    s_hs  = (out_valid === 1'b1) && (out_ready === 1'b1);
    s_ovf = (fifo_overflow === 1'b1);
    prev_data  = out_data;
    prev_valid = (out_valid === 1'b1);
    prev_hs    = s_hs;
    prev_rst   = s_rst;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int pushed;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_fifo_read", 64'(fifo_read), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    check("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);

    // Basic pair with both words present: out_valid in the 6th cycle,
    // counting the first IDLE cycle that sees fifo_ready as cycle 1.
    step();
    rd_pulses = 0;
    push(12'h001);
    push(12'h002);
    @(negedge clk);
    wait_valid(n);
    check("basic_latency", 64'(n), 64'd6);
    check("basic_data", 64'(out_data), 64'h002001);
    @(negedge clk);
    check("basic_valid_one_cycle", 64'(out_valid), 64'd0);
    check("basic_read_pulses", 64'(rd_pulses), 64'd2);
    check("basic_pair_cnt", 64'(pair_cnt), 64'd1);

    // Backpressure for 10 cycles in OUT
    step();
    out_ready = 1'b0;
    rd_pulses = 0;
    push(12'h003);
    push(12'h004);
    wait_valid(n);
    check("bp_data", 64'(out_data), 64'h004003);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_data_held", 64'(out_data), 64'h004003);
      check("bp_cnt_held", 64'(pair_cnt), 64'd1);
    end
    check("bp_read_pulses", 64'(rd_pulses), 64'd2);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_pair_cnt", 64'(pair_cnt), 64'd2);
    check("bp_valid_dropped", 64'(out_valid), 64'd0);

    // Empty gap: second word arrives later, FSM parks without reading
    step();
    push(12'h0e0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_no_read", 64'(fifo_read), 64'd0);
      check("gap_no_valid", 64'(out_valid), 64'd0);
    end
    step();
    push(12'h005);
    wait_valid(n);
    check("gap_data", 64'(out_data), 64'h0050e0);
    @(negedge clk);

    // Reset during CAP_LO discards the half pair
    step();
    push(12'h0aa);
    push(12'h0bb);
    repeat (3) @(negedge clk);
    check("midrst_rd_lo_strobe", 64'(fifo_read), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_fifo_read", 64'(fifo_read), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_data", 64'(out_data), 64'd0);
      check("midrst_cnt", 64'(pair_cnt), 64'd0);
      check("midrst_sticky", 64'(ovf_sticky), 64'd0);
      @(negedge clk);
    end
    step();
    push(12'h0cc);
    wait_valid(n);
    check("midrst_next_pair", 64'(out_data), 64'h0cc0bb);
    @(negedge clk);
    check("midrst_next_cnt", 64'(pair_cnt), 64'd1);

    // 256 randomized pairs wrap the counter to 0
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = total_hs;
    pushed = 0;
    for (int cyc = 0; cyc < 20000 && (total_hs - base) < 256; cyc++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 512 && $urandom_range(0, 1) == 1) begin
        push(BITS'($urandom_range(0, 4095)));
        pushed++;
      end
    end
    out_ready = 1'b1;
    check("wrap_handshakes", 64'(total_hs - base), 64'd256);
    @(negedge clk);
    check("wrap_pair_cnt", 64'(pair_cnt), 64'd0);

    // Sticky overflow flag
    step();
    fifo_overflow = 1'b1;
    @(negedge clk);
    check("ovf_not_yet", 64'(ovf_sticky), 64'd0);
    @(posedge clk);
    #2 fifo_overflow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ovf_held", 64'(ovf_sticky), 64'd1);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 64'(ovf_sticky), 64'd0);

`ifdef PACKER_PARITY_EN
    // Parity of two hand-picked pairs
    step();
    push(12'h003);
    push(12'h000);
    wait_valid(n);
    check("par_data_3", 64'(out_data), 64'h000003);
    check("par_even", 64'(out_parity), 64'd0);
    @(negedge clk);
    step();
    push(12'h001);
    push(12'h000);
    wait_valid(n);
    check("par_data_1", 64'(out_data), 64'h000001);
    check("par_odd", 64'(out_parity), 64'd1);
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
